flash_prog_ctrl: RTL and testbench

Command-level sequencer for the flash driver. Accepts host commands (block erase, program N words, read N words), streams data in and out, and breaks each command into single-word driver operations. It issues each operation with the driver's enable/busy handshake and optionally verifies every programmed word by read-back. Sits between the bootloader/UART loader and the flash driver.

---
 rtl/flash_ctrl_pkg.sv | 43 ++++
 rtl/flash_op_issuer.sv | 168 ++++++++++++++++
 rtl/flash_prog_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_flash_prog_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_ctrl_pkg.sv
// Shared types for the flash command sequencer: host op codes, error codes,
// driver operation kinds and the state encodings of both FSMs.
package flash_ctrl_pkg;

    localparam int ADDR_W_DEF = 22;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_PROGRAM = 2'b01,
        OP_ERASE   = 2'b10,
        OP_RSVD    = 2'b11
    } cmd_op_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_VERIFY  = 2'b10;
    localparam logic [1:0] ERR_RSVD_OP = 2'b11;

    typedef enum logic [1:0] {
        OPK_READ,
        OPK_WRITE,
        OPK_ERASE
    } op_kind_e;

    typedef enum logic [2:0] {
        IS_IDLE,
        IS_WAIT_ACK,
        IS_WAIT_DONE,
        IS_RD_CAPTURE,
        IS_RD_RELEASE
    } iss_state_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WDATA,
        S_WAIT_OP,
        S_NEXT,
        S_DONE,
        S_ERR
    } ctrl_state_e;

endpackage

// File: rtl/flash_op_issuer.sv
// Runs one single-word driver operation (read, write or erase) through the
// driver's enable/busy handshake, with an acknowledge timeout.
module flash_op_issuer
    import flash_ctrl_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ACK_TIMEOUT = 255,
    parameter int RELEASE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  op_kind_e          kind,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              op_done,
    output logic              op_timeout,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] drv_addr,
    output logic [DATA_W-1:0] drv_wdata,
    input  logic [DATA_W-1:0] drv_rdata,
    output logic              drv_en_read,
    output logic              drv_en_erase,
    output logic              drv_en_write,
    input  logic              drv_busy
);

    localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int REL_W = (RELEASE_CYC > 1) ? $clog2(RELEASE_CYC) : 1;

    iss_state_e        state_q, state_d;
    op_kind_e          kind_q, kind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              en_rd_q, en_rd_d;
    logic              en_wr_q, en_wr_d;
    logic              en_er_q, en_er_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [REL_W-1:0]  rel_q, rel_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;

    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        en_rd_d = en_rd_q;
        en_wr_d = en_wr_q;
        en_er_d = en_er_q;
        timer_d = timer_q;
        rel_d   = rel_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;

        unique case (state_q)
            IS_IDLE: begin
                if (start) begin
                    kind_d  = kind;
                    addr_d  = addr;
                    if (kind == OPK_WRITE) begin
                        wdata_d = wdata;
                    end
                    en_rd_d = (kind == OPK_READ);
                    en_wr_d = (kind == OPK_WRITE);
                    en_er_d = (kind == OPK_ERASE);
                    timer_d = '0;
                    state_d = IS_WAIT_ACK;
                end
            end
            IS_WAIT_ACK: begin
                if (drv_busy) begin
                    // Reads keep the enable and address through busy; the
                    // driver only presents data while en_read is still high.
                    en_wr_d = 1'b0;
                    en_er_d = 1'b0;
                    state_d = IS_WAIT_DONE;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    en_rd_d = 1'b0;
                    en_wr_d = 1'b0;
                    en_er_d = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = IS_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            IS_WAIT_DONE: begin
                if (!drv_busy) begin
                    if (kind_q == OPK_READ) begin
                        state_d = IS_RD_CAPTURE;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IS_IDLE;
                    end
                end
            end
            IS_RD_CAPTURE: begin
                rdata_d = drv_rdata;
                en_rd_d = 1'b0;
                rel_d   = '0;
                if (RELEASE_CYC == 0) begin
                    done_d  = 1'b1;
                    state_d = IS_IDLE;
                end else begin
                    state_d = IS_RD_RELEASE;
                end
            end
            IS_RD_RELEASE: begin
                if (rel_q == REL_W'(RELEASE_CYC - 1)) begin
                    done_d  = 1'b1;
                    state_d = IS_IDLE;
                end else begin
                    rel_d = rel_q + REL_W'(1);
                end
            end
            default: begin
                en_rd_d = 1'b0;
                en_wr_d = 1'b0;
                en_er_d = 1'b0;
                state_d = IS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IS_IDLE;
            kind_q  <= OPK_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            en_rd_q <= 1'b0;
            en_wr_q <= 1'b0;
            en_er_q <= 1'b0;
            timer_q <= '0;
            rel_q   <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            en_rd_q <= en_rd_d;
            en_wr_q <= en_wr_d;
            en_er_q <= en_er_d;
            timer_q <= timer_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign op_done      = done_q;
    assign op_timeout   = tmo_q;
    assign rdata        = rdata_q;
    assign drv_addr     = addr_q;
    assign drv_wdata    = wdata_q;
    assign drv_en_read  = en_rd_q;
    assign drv_en_write = en_wr_q;
    assign drv_en_erase = en_er_q;

endmodule

// File: rtl/flash_prog_ctrl.sv
// Command-level flash sequencer: splits host READ/PROGRAM/ERASE commands into
// single-word driver operations, streams data and optionally verifies writes.
module flash_prog_ctrl
    import flash_ctrl_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int LEN_W       = 16,
    parameter int VERIFY      = 1,
    parameter int ACK_TIMEOUT = 255,
    parameter int RELEASE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W-1:0] drv_addr,
    output logic [DATA_W-1:0] drv_wdata,
    input  logic [DATA_W-1:0] drv_rdata,
    output logic              drv_en_read,
    output logic              drv_en_erase,
    output logic              drv_en_write,
    input  logic              drv_busy
);

    ctrl_state_e       state_q, state_d;
    cmd_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              start_q, start_d;
    op_kind_e          kind_q, kind_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              wr_ready_q, wr_ready_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              op_done;
    logic              op_timeout;
    logic [DATA_W-1:0] op_rdata;
    cmd_op_e           cmd_op_in;

    assign cmd_op_in = cmd_op_e'(cmd_op);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        start_d     = 1'b0;
        kind_d      = kind_q;
        cmd_ready_d = cmd_ready_q;
        wr_ready_d  = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        done_d      = 1'b0;
        error_d     = error_q;
        err_code_d  = err_code_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    error_d     = 1'b0;
                    err_code_d  = ERR_NONE;
                    op_d        = cmd_op_in;
                    addr_d      = cmd_addr;
                    len_d       = cmd_len;
                    unique case (cmd_op_in)
                        OP_RSVD: begin
                            error_d    = 1'b1;
                            err_code_d = ERR_RSVD_OP;
                            state_d    = S_ERR;
                        end
                        OP_ERASE: begin
                            start_d = 1'b1;
                            kind_d  = OPK_ERASE;
                            state_d = S_WAIT_OP;
                        end
                        default: begin
                            if (cmd_len == '0) begin
                                state_d = S_DONE;
                            end else if (cmd_op_in == OP_PROGRAM) begin
                                state_d = S_WAIT_WDATA;
                            end else begin
                                start_d = 1'b1;
                                kind_d  = OPK_READ;
                                state_d = S_WAIT_OP;
                            end
                        end
                    endcase
                end
            end
            S_WAIT_WDATA: begin
                if (wr_valid) begin
                    wdata_d    = wr_data;
                    wr_ready_d = 1'b1;
                    start_d    = 1'b1;
                    kind_d     = OPK_WRITE;
                    state_d    = S_WAIT_OP;
                end
            end
            S_WAIT_OP: begin
                if (op_timeout) begin
                    error_d    = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_ERR;
                end else if (op_done) begin
                    unique case (kind_q)
                        OPK_ERASE: state_d = S_DONE;
                        OPK_WRITE: begin
                            if (VERIFY != 0) begin
                                start_d = 1'b1;
                                kind_d  = OPK_READ;
                            end else begin
                                state_d = S_NEXT;
                            end
                        end
                        default: begin
                            // A read inside PROGRAM is the verify read-back.
                            if (op_q == OP_PROGRAM) begin
                                if (op_rdata != wdata_q) begin
                                    error_d    = 1'b1;
                                    err_code_d = ERR_VERIFY;
                                    state_d    = S_ERR;
                                end else begin
                                    state_d = S_NEXT;
                                end
                            end else begin
                                rd_valid_d = 1'b1;
                                rd_data_d  = op_rdata;
                                state_d    = S_NEXT;
                            end
                        end
                    endcase
                end
            end
            S_NEXT: begin
                addr_d = addr_q + ADDR_W'(1);
                len_d  = len_q - LEN_W'(1);
                if (len_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                end else if (op_q == OP_PROGRAM) begin
                    state_d = S_WAIT_WDATA;
                end else begin
                    start_d = 1'b1;
                    kind_d  = OPK_READ;
                    state_d = S_WAIT_OP;
                end
            end
            S_DONE, S_ERR: begin
                done_d      = 1'b1;
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            start_q     <= 1'b0;
            kind_q      <= OPK_READ;
            cmd_ready_q <= 1'b1;
            wr_ready_q  <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            start_q     <= start_d;
            kind_q      <= kind_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    flash_op_issuer #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .RELEASE_CYC (RELEASE_CYC)
    ) u_issuer (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_q),
        .kind         (kind_q),
        .addr         (addr_q),
        .wdata        (wdata_q),
        .op_done      (op_done),
        .op_timeout   (op_timeout),
        .rdata        (op_rdata),
        .drv_addr     (drv_addr),
        .drv_wdata    (drv_wdata),
        .drv_rdata    (drv_rdata),
        .drv_en_read  (drv_en_read),
        .drv_en_erase (drv_en_erase),
        .drv_en_write (drv_en_write),
        .drv_busy     (drv_busy)
    );

    assign cmd_ready = cmd_ready_q;
    assign wr_ready  = wr_ready_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Randomized bench for flash_prog_ctrl: a flash driver model answers the
// handshake and a word-level reference predicts ops, read data and status.
module tb_flash_prog_ctrl;

    localparam int VERIFY = 1;

    typedef struct {
        int kind;   // 0 read, 1 write, 2 erase
        int addr;
        int data;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [21:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic [15:0] drv_rdata = '0;
    logic        drv_busy = 1'b0;
    logic        cmd_ready, wr_ready, rd_valid, done, error;
    logic [15:0] rd_data, drv_wdata;
    logic [1:0]  err_code;
    logic [21:0] drv_addr;
    logic        drv_en_read, drv_en_erase, drv_en_write;

    int total = 0;
    int bad = 0;

    logic [15:0] mem [int];
    logic [15:0] ref_mem [int];
    logic [15:0] wq [$];
    op_t obs_ops [$];
    op_t exp_ops [$];
    int  obs_rd [$];
    int  exp_rd [$];
    int  exp_err, exp_code;
    int  done_cnt = 0, erase_hi = 0, overlap_cnt = 0, stab_err = 0;
    bit  ack_disable = 1'b0;
    logic [15:0] rd_xor = '0;
    int  erase_dur = 50, op_dur_min = 2, op_dur_max = 5;

    flash_prog_ctrl #(
        .ADDR_W(22), .DATA_W(16), .LEN_W(16), .VERIFY(VERIFY),
        .ACK_TIMEOUT(255), .RELEASE_CYC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .error(error), .err_code(err_code),
        .drv_addr(drv_addr), .drv_wdata(drv_wdata), .drv_rdata(drv_rdata),
        .drv_en_read(drv_en_read), .drv_en_erase(drv_en_erase),
        .drv_en_write(drv_en_write), .drv_busy(drv_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [21:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 16'hA000 + a[15:0];
    endfunction

    function automatic int ref_read(input int a);
        if (ref_mem.exists(a)) return int'(ref_mem[a]);
        return (32'hA000 + (a & 32'hFFFF)) & 32'hFFFF;
    endfunction

    // Flash driver model: answers a rising enable with busy, commits writes
    // and presents read data when busy falls.
    initial begin
        int phase, cnt, kind;
        logic [21:0] a;
        logic [15:0] d;
        logic pr, pw, pe;
        phase = 0; cnt = 0; kind = 0; a = '0; d = '0; pr = 0; pw = 0; pe = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                phase = 0; drv_busy = 1'b0; pr = 0; pw = 0; pe = 0;
            end else begin
                if (phase == 1) begin
                    if (cnt == 0) begin
                        drv_busy = 1'b1;
                        phase = 2;
                        cnt = (kind == 2) ? erase_dur : int'($urandom_range(op_dur_max, op_dur_min));
                    end else cnt--;
                end else if (phase == 2) begin
                    if (cnt <= 1) begin
                        drv_busy = 1'b0;
                        phase = 0;
                        if (kind == 1) mem[int'(a)] = d;
                        else if (kind == 0) drv_rdata = model_read(a) ^ rd_xor;
                    end else cnt--;
                end
                if (phase == 0 && !ack_disable) begin
                    if ((drv_en_read && !pr) || (drv_en_write && !pw) || (drv_en_erase && !pe)) begin
                        kind = drv_en_read ? 0 : (drv_en_write ? 1 : 2);
                        a = drv_addr;
                        d = drv_wdata;
                        phase = 1;
                        cnt = int'($urandom_range(2, 0));
                    end
                end
                pr = drv_en_read; pw = drv_en_write; pe = drv_en_erase;
            end
        end
    end

    // Monitor: records issued operations, read data, done pulses, exclusivity.
    initial begin
        logic pr, pw, pe;
        logic [21:0] held;
        op_t o;
        pr = 0; pw = 0; pe = 0; held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pr = 0; pw = 0; pe = 0;
            end else begin
                if ((int'(drv_en_read) + int'(drv_en_write) + int'(drv_en_erase)) > 1) overlap_cnt++;
                if ((drv_en_read && pr) || (drv_en_write && pw) || (drv_en_erase && pe)) begin
                    if (drv_addr !== held) stab_err++;
                end
                if ((drv_en_read && !pr) || (drv_en_write && !pw) || (drv_en_erase && !pe)) begin
                    o.kind = drv_en_read ? 0 : (drv_en_write ? 1 : 2);
                    o.addr = int'(drv_addr);
                    o.data = int'(drv_wdata);
                    obs_ops.push_back(o);
                    held = drv_addr;
                end
                if (rd_valid) obs_rd.push_back(int'(rd_data));
                if (done) done_cnt++;
                if (drv_en_erase) erase_hi++;
                pr = drv_en_read; pw = drv_en_write; pe = drv_en_erase;
            end
        end
    end

    task automatic build_expect(input int op, input int addr, input int len, input int xr, input bit noack);
        op_t o;
        int a, d;
        exp_ops.delete(); exp_rd.delete(); exp_err = 0; exp_code = 0;
        if (op == 3) begin
            exp_err = 1; exp_code = 3;
        end else if (op == 2) begin
            o.kind = 2; o.addr = addr; o.data = 0; exp_ops.push_back(o);
            if (noack) begin exp_err = 1; exp_code = 1; end
        end else begin
            for (int i = 0; i < len; i++) begin
                a = (addr + i) & 32'h3FFFFF;
                if (op == 1) begin
                    d = int'(wq[i]);
                    o.kind = 1; o.addr = a; o.data = d; exp_ops.push_back(o);
                    ref_mem[a] = wq[i];
                    if (VERIFY != 0) begin
                        o.kind = 0; o.data = 0; exp_ops.push_back(o);
                        if (((d ^ xr) & 32'hFFFF) != d) begin
                            exp_err = 1; exp_code = 2;
                            break;
                        end
                    end
                end else begin
                    o.kind = 0; o.addr = a; o.data = 0; exp_ops.push_back(o);
                    exp_rd.push_back((ref_read(a) ^ xr) & 32'hFFFF);
                end
            end
        end
    endtask

    task automatic run_cmd(input int op, input int addr, input int len, input int xr, input bit noack);
        int cyc, k;
        build_expect(op, addr, len, xr, noack);
        rd_xor = xr[15:0];
        ack_disable = noack;
        obs_ops.delete(); obs_rd.delete(); done_cnt = 0; erase_hi = 0;
        cyc = 0;
        while (!cmd_ready && cyc < 1000) begin @(negedge clk); cyc++; end
        cmd_valid = 1'b1; cmd_op = op[1:0]; cmd_addr = addr[21:0]; cmd_len = len[15:0];
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 0; cyc = 0;
        while (!done && cyc < 4000) begin
            if (wr_ready) k++;
            wr_valid = (op == 1) && (k < len);
            wr_data = (k < wq.size()) ? wq[k] : 16'h0;
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
        chk("done_seen", int'(done), 1);
        repeat (4) @(negedge clk);
        chk("done_count", done_cnt, 1);
        chk("error", int'(error), exp_err);
        chk("err_code", int'(err_code), exp_code);
        chk("n_ops", obs_ops.size(), exp_ops.size());
        foreach (exp_ops[i]) begin
            if (i < obs_ops.size()) begin
                chk("op_kind", obs_ops[i].kind, exp_ops[i].kind);
                chk("op_addr", obs_ops[i].addr, exp_ops[i].addr);
                if (exp_ops[i].kind == 1) chk("op_wdata", obs_ops[i].data, exp_ops[i].data);
            end
        end
        chk("n_rd", obs_rd.size(), exp_rd.size());
        foreach (exp_rd[i]) begin
            if (i < obs_rd.size()) chk("rd_data", obs_rd[i], exp_rd[i]);
        end
        chk("idle_enables", int'(drv_en_read) + int'(drv_en_write) + int'(drv_en_erase), 0);
        $display("cmd op=%0d addr=%06h len=%0d ops=%0d rd=%0d err=%0d code=%0d",
                 op, addr, len, obs_ops.size(), obs_rd.size(), error, err_code);
        ack_disable = 1'b0;
        rd_xor = '0;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_cmd_ready"}, int'(cmd_ready), 1);
        chk({pfx, "_enables"}, int'(drv_en_read) + int'(drv_en_write) + int'(drv_en_erase), 0);
        chk({pfx, "_wr_ready"}, int'(wr_ready), 0);
        chk({pfx, "_rd_valid"}, int'(rd_valid), 0);
        chk({pfx, "_done"}, int'(done), 0);
        chk({pfx, "_error"}, int'(error), 0);
        chk({pfx, "_err_code"}, int'(err_code), 0);
        chk({pfx, "_drv_addr"}, int'(drv_addr), 0);
        chk({pfx, "_drv_wdata"}, int'(drv_wdata), 0);
        chk({pfx, "_rd_data"}, int'(rd_data), 0);
    endtask

    initial begin
        int op, addr, len, xr, cyc;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        erase_dur = 50;
        run_cmd(2, 32'h000100, 0, 0, 1'b0);

        wq.delete(); wq.push_back(16'h1234); wq.push_back(16'h5678); wq.push_back(16'h9ABC);
        run_cmd(1, 32'h3FFFFE, 3, 0, 1'b0);

        run_cmd(0, 32'h000010, 4, 0, 1'b0);

        wq.delete(); wq.push_back(16'h00FF);
        run_cmd(1, 32'h000040, 1, 32'h0001, 1'b0);

        run_cmd(2, 32'h000055, 0, 0, 1'b1);
        chk("timeout_en_cycles", erase_hi, 255);

        run_cmd(0, 32'h000020, 0, 0, 1'b0);
        run_cmd(3, 32'h000000, 2, 0, 1'b0);

        // Reset while a write is in its busy phase.
        op_dur_min = 10; op_dur_max = 10;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 22'h000200; cmd_len = 16'd1;
        @(negedge clk);
        cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 16'h5555;
        cyc = 0;
        while (!(drv_busy && !drv_en_write && !wr_valid) && cyc < 500) begin
            @(negedge clk);
            if (wr_ready) wr_valid = 1'b0;
            cyc++;
        end
        chk("rst_reach_wait_done", int'(cyc < 500), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op_dur_min = 2; op_dur_max = 5;
        repeat (2) @(negedge clk);
        run_cmd(0, 32'h000300, 1, 0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            op = int'($urandom_range(9, 0));
            op = (op < 4) ? 0 : (op < 8) ? 1 : (op == 8) ? 2 : 3;
            addr = ($urandom_range(3, 0) == 0) ? (32'h3FFFFC + int'($urandom_range(3, 0)))
                                               : int'($urandom & 32'h3FFFFF);
            len = int'($urandom_range(4, 0));
            xr = 0;
            wq.delete();
            for (int i = 0; i < len; i++) wq.push_back(16'($urandom));
            if (op == 1 && $urandom_range(7, 0) == 0) xr = 1 << $urandom_range(15, 0);
            erase_dur = int'($urandom_range(20, 3));
            run_cmd(op, addr, len, xr, 1'b0);
        end

        chk("enable_overlap", overlap_cnt, 0);
        chk("addr_stable", stab_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
